// File: rtl/fsm_step_driver.sv
// Sequencer and self-checker for the 9-state step FSM: fires one advance strobe per
// state after a programmable dwell, then confirms that the FSM actually moved.
module fsm_step_driver #(
    parameter int DW = 4,
    parameter int LW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic [3:0]    y,
    input  logic          run,
    input  logic [DW-1:0] dwell,
    output logic          i0,
    output logic          i1,
    output logic          i2,
    output logic          i3,
    output logic          i4,
    output logic          i5,
    output logic          i6,
    output logic          i7,
    output logic          i8,
    output logic          lap_done,
    output logic [LW-1:0] lap_count,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIRE, S_CHECK} state_t;

    state_t        state;
    logic [3:0]    exp;
    logic [DW-1:0] cnt;
    logic [8:0]    strb;
    logic [3:0]    nxt;
    logic          out_of_range;

    function automatic logic [3:0] succ(input logic [3:0] s);
        return (s == 4'd8) ? 4'd0 : s + 4'd1;
    endfunction

    function automatic logic [8:0] strobe_for(input logic [3:0] s);
        return 9'd1 << s;
    endfunction

    assign nxt          = succ(exp);
    assign out_of_range = (y > 4'd8);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            exp       <= 4'd0;
            cnt       <= '0;
            strb      <= '0;
            lap_done  <= 1'b0;
            lap_count <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            lap_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    strb <= '0;
                    busy <= 1'b0;
                    if (run && y == 4'd0 && !err) begin
                        exp   <= 4'd0;
                        cnt   <= dwell;
                        state <= S_WAIT;
                        busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // exp never exceeds 8, so this also catches an out-of-range y
                    if (y != exp) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        strb  <= '0;
                    end else if (en) begin
                        if (cnt == '0) begin
                            state <= S_FIRE;
                            strb  <= strobe_for(exp);
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                S_FIRE: begin
                    // y still shows exp here; the FSM moves on the edge that leaves FIRE
                    if (out_of_range) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        strb  <= '0;
                    end else if (en) begin
                        state <= S_CHECK;
                        strb  <= '0;
                    end
                end
                S_CHECK: begin
                    if (y != nxt) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        strb  <= '0;
                    end else begin
                        exp <= nxt;
                        if (nxt == 4'd0) begin
                            lap_done  <= 1'b1;
                            lap_count <= lap_count + 1'b1;
                        end
                        // run is only honoured at the lap boundary
                        if (nxt == 4'd0 && !run) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt   <= dwell;
                            state <= S_WAIT;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    strb  <= '0;
                end
            endcase
        end
    end

    assign i0 = strb[0];
    assign i1 = strb[1];
    assign i2 = strb[2];
    assign i3 = strb[3];
    assign i4 = strb[4];
    assign i5 = strb[5];
    assign i6 = strb[6];
    assign i7 = strb[7];
    assign i8 = strb[8];

endmodule
